clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Checks the divided clock pair (clk, mem_clk) from the divider; runs on the 100 MHz clkin.
//  Measures clk half-period in clkin cycles and declares lock after consecutive in-tolerance intervals.
//  Latches faults for period drift, stall and (optionally) loss of clk/mem_clk complementarity.
//  Sits beside the divider in the top level; drives the status LEDs and the debug counters.
// PARAMETERS
//  CNT_W     24     width of interval counter / half_period
//  EXP_HALF  10001  expected clkin cycles between consecutive clk edges (divider toggles every 10001)
//  TOL       2      allowed +/- deviation from EXP_HALF, inclusive
//  LOCK_CNT  4      consecutive good intervals required to enter LOCKED (>=1)
// PORTS
//  clkin        in   1      100 MHz system clock; all logic on posedge
//  reset        in   1      synchronous, active-high
//  clk_mon      in   1      divided clk to monitor (asynchronous to clkin phase)
//  mem_clk_mon  in   1      divided mem_clk to monitor
//  clear_fault  in   1      1-cycle pulse: leave FAULT, return to IDLE
//  half_period  out  CNT_W  last measured interval, clkin cycles
//  period_vld   out  1      1-cycle pulse when half_period updates
//  locked       out  1      high only in LOCKED
//  fault        out  1      high only in FAULT
//  fault_code   out  2      01 period, 10 stall, 11 phase; 00 when no fault
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, synchronizers 0.
//  - Inputs pass 2-flop synchronizers; edge = sync_q != sync_qq (either polarity). Edge->effect latency: 3 clkin.
//  - Interval counter cnt: on edge, half_period<=cnt+1, period_vld=1, cnt<=0; else cnt+1, saturating at 2^CNT_W-1.
//  - good = |half_period_new - EXP_HALF| <= TOL; compare in CNT_W+1 bits, no wrap.
//  - FSM:
//    IDLE  : first edge discards the partial interval (no period_vld), -> ACQ, good_cnt=0.
//    ACQ   : edge & good -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCKED (locked high next cycle).
//            edge & !good -> good_cnt=0, stay. cnt > EXP_HALF+TOL -> IDLE (stall before lock is not a fault).
//    LOCKED: edge & !good -> FAULT code 01. cnt > EXP_HALF+TOL with no edge -> FAULT code 10.
//            phase error (see CONFIGURATION) -> FAULT code 11.
//    FAULT : sticky; fault_code held; measurement continues (half_period/period_vld still update).
//            clear_fault -> IDLE, fault_code<=00.
//  - Same-cycle fault priority: stall 10 > period 01 > phase 11.
//  - clear_fault outside FAULT: ignored. clear_fault same cycle as new fault detection: clear wins (-> IDLE).
//  - Reset mid-operation: immediate return to reset values on that edge; no partial state kept.
// CONFIGURATION
//  CLK_MON_PHASE_CHK_EN defined:
//    - in LOCKED, synced clk == synced mem_clk for 2 consecutive clkin cycles -> FAULT 11.
//    - one equal cycle tolerated for synchronizer skew.
//  undefined: mem_clk_mon unused, no phase logic, code 11 never produced.
// STRUCTURE
//  clk_mon_pkg: state enum {IDLE,ACQ,LOCKED,FAULT}; fault code constants FC_NONE/FC_PERIOD/FC_STALL/FC_PHASE.
//  Sub-module sync_edge_det (2-flop sync + edge pulse, outputs level and edge).
//  Instantiate once for clk_mon, and once for mem_clk_mon under the macro.
// TESTING (bench params EXP_HALF=10, TOL=1, LOCK_CNT=4, CNT_W=8)
//  1 clk_mon toggles every 10 clkin -> period_vld pulses with half_period=10; locked rises after 4th good edge.
//  2 Locked, one interval of 13 -> fault=1, fault_code=01, locked=0.
//    clear_fault -> IDLE; relock after 1+4 edges.
//  3 Locked, clk_mon frozen -> fault_code=10 when cnt reaches 12.
//    Same freeze in ACQ -> back to IDLE, fault stays 0.
//  4 Intervals 9,11,9,11 -> lock (within TOL). Intervals 10,10,12,10,10,10,10 -> good_cnt restarts; lock only after last 4.
//  5 PHASE_CHK_EN, locked, mem_clk_mon forced equal to clk_mon -> fault_code=11.
//    Single-cycle equality glitch -> no fault. Without macro -> no fault ever.
//  6 reset asserted while FAULT and mid-interval -> all outputs 0 on next edge; clear_fault+fault same cycle -> IDLE.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_mon_pkg;

  // Monitor states: hunting for first edge, acquiring lock, locked, sticky fault.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_e;

  // Fault codes reported on fault_code.
  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_PERIOD = 2'b01;
  localparam logic [1:0] FC_STALL  = 2'b10;
  localparam logic [1:0] FC_PHASE  = 2'b11;

  // Same-cycle fault arbitration: stall beats period beats phase.
  function automatic logic [1:0] pick_fault(input logic stall_hit,
                                            input logic period_hit,
                                            input logic phase_hit);
    logic [1:0] code;
    code = FC_NONE;
    if (stall_hit) begin
      code = FC_STALL;
    end else if (period_hit) begin
      code = FC_PERIOD;
    end else if (phase_hit) begin
      code = FC_PHASE;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by one extra stage for edge detection.
// level is the synchronized input; edge_pulse is high for one clkin cycle after
// either polarity of transition has passed through the synchronizer.
module sync_edge_det (
  input  logic clkin,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic sync_qq;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge clkin) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      sync_qq <= sync_q;
    end
  end

  assign level      = sync_q;
  assign edge_pulse = sync_q != sync_qq;

endmodule

// File: rtl/clk_div_monitor.sv
// Monitors the divided clock pair from the clock divider, running on clkin.
// Measures the clk half-period in clkin cycles, declares lock after LOCK_CNT
// consecutive in-tolerance intervals and latches period/stall/phase faults.
// Optional feature macro: CLK_MON_PHASE_CHK_EN enables the clk/mem_clk
// complementarity check; without it mem_clk_mon is ignored.
module clk_div_monitor #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned EXP_HALF = 10001,
  parameter int unsigned TOL      = 2,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             clk_mon,
  input  logic             mem_clk_mon,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] half_period,
  output logic             period_vld,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  import clk_mon_pkg::*;

  localparam int unsigned       GC_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]    EXP_W   = (CNT_W + 1)'(EXP_HALF);
  localparam logic [CNT_W:0]    TOL_W   = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W:0]    LIM_W   = (CNT_W + 1)'(EXP_HALF + TOL);
  localparam logic [GC_W-1:0]   GC_LOCK = GC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Synchronized monitor inputs
  logic clk_lvl;
  logic clk_edge;
  logic phase_err;

  // Interval measurement
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   meas;
  logic [CNT_W:0]   dev;
  logic [CNT_W-1:0] meas_sat;
  logic             good;
  logic             stall;
  logic             report;

  // Lock/fault state
  mon_state_e       state_q;
  mon_state_e       state_d;
  logic [GC_W-1:0]  good_cnt_q;
  logic [GC_W-1:0]  good_cnt_d;
  logic [GC_W-1:0]  good_cnt_inc;
  logic [1:0]       fault_code_q;
  logic [1:0]       fault_code_d;
  logic [1:0]       new_code;

  sync_edge_det u_sync_clk (
    .clkin      (clkin),
    .reset      (reset),
    .din        (clk_mon),
    .level      (clk_lvl),
    .edge_pulse (clk_edge)
  );

`ifdef CLK_MON_PHASE_CHK_EN
  logic mem_lvl;
  logic unused_mem_edge;
  logic eq_q;

  sync_edge_det u_sync_mem (
    .clkin      (clkin),
    .reset      (reset),
    .din        (mem_clk_mon),
    .level      (mem_lvl),
    .edge_pulse (unused_mem_edge)
  );

  // Remember last cycle's equality so a single skewed cycle is tolerated.
  always_ff @(posedge clkin) begin
    if (reset) begin
      eq_q <= 1'b0;
    end else begin
      eq_q <= (clk_lvl == mem_lvl);
    end
  end

  assign phase_err = eq_q && (clk_lvl == mem_lvl);
`else
  logic unused_mem_clk;
  assign unused_mem_clk = mem_clk_mon;
  assign phase_err      = 1'b0;
`endif

  // Interval arithmetic: widened by one bit so the tolerance compare cannot wrap.
  always_comb begin
    meas     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    dev      = (meas >= EXP_W) ? (meas - EXP_W) : (EXP_W - meas);
    good     = dev <= TOL_W;
    stall    = {1'b0, cnt_q} > LIM_W;
    meas_sat = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
    // The first edge out of IDLE closes a partial interval, so it is not reported.
    report   = clk_edge && (state_q != IDLE);
    if (clk_edge) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Interval counter and reported half-period.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt_q       <= '0;
      half_period <= '0;
      period_vld  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_vld <= report;
      if (report) begin
        half_period <= meas_sat;
      end
    end
  end

  // Next-state logic for acquisition, lock and sticky fault.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    fault_code_d = fault_code_q;
    good_cnt_inc = good_cnt_q + 1'b1;
    new_code     = FC_NONE;

    unique case (state_q)
      IDLE: begin
        if (clk_edge) begin
          state_d    = ACQ;
          good_cnt_d = '0;
        end
      end

      ACQ: begin
        // A late edge is simply a bad interval; stall only applies with no edge.
        if (clk_edge) begin
          if (good) begin
            good_cnt_d = good_cnt_inc;
            if (good_cnt_inc == GC_LOCK) begin
              state_d = LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (stall) begin
          state_d    = IDLE;
          good_cnt_d = '0;
        end
      end

      LOCKED: begin
        new_code = pick_fault(stall && !clk_edge, clk_edge && !good, phase_err);
        if (new_code != FC_NONE) begin
          // A clear arriving with the detection wins and restarts acquisition.
          if (clear_fault) begin
            state_d      = IDLE;
            fault_code_d = FC_NONE;
          end else begin
            state_d      = FAULT;
            fault_code_d = new_code;
          end
          good_cnt_d = '0;
        end
      end

      FAULT: begin
        if (clear_fault) begin
          state_d      = IDLE;
          fault_code_d = FC_NONE;
          good_cnt_d   = '0;
        end
      end

      default: begin
        state_d      = IDLE;
        good_cnt_d   = '0;
        fault_code_d = FC_NONE;
      end
    endcase
  end

  // State, lock progress and latched fault code.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign locked     = state_q == LOCKED;
  assign fault      = state_q == FAULT;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with EXP_HALF=10, TOL=1, LOCK_CNT=4, CNT_W=8.
// clk_mon is toggled on clkin negedges; each toggle_wait call toggles once and
// then waits n clkin cycles, so the interval measured at a toggle equals the
// n of the previous call. Edge effects appear 3 clkin cycles after a toggle.
module tb_clk_div_monitor;

  logic       clkin;
  logic       reset;
  logic       clk_mon;
  logic       mem_clk_mon;
  logic       clear_fault;
  logic [7:0] half_period;
  logic       period_vld;
  logic       locked;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  logic       track_mem;
  logic       v, v4, lk, fl, bad;
  logic [7:0] hp;
  logic [1:0] fc;

  clk_div_monitor #(
    .CNT_W    (8),
    .EXP_HALF (10),
    .TOL      (1),
    .LOCK_CNT (4)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .clk_mon     (clk_mon),
    .mem_clk_mon (mem_clk_mon),
    .clear_fault (clear_fault),
    .half_period (half_period),
    .period_vld  (period_vld),
    .locked      (locked),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic do_reset();
    reset       = 1'b1;
    clk_mon     = 1'b0;
    mem_clk_mon = 1'b1;
    clear_fault = 1'b0;
    track_mem   = 1'b1;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    reset = 1'b0;
  endtask

  // Toggle clk_mon, wait n cycles, snapshot outputs 3 and 4 cycles after the toggle.
  task automatic toggle_wait(input int n, output logic o_v, output logic o_v4,
                             output logic [7:0] o_hp, output logic o_lk,
                             output logic o_fl, output logic [1:0] o_fc);
    clk_mon = ~clk_mon;
    if (track_mem) mem_clk_mon = ~clk_mon;
    o_v4 = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clkin);
      @(negedge clkin);
      if (i == 3) begin
        o_v  = period_vld;
        o_hp = half_period;
        o_lk = locked;
        o_fl = fault;
        o_fc = fault_code;
      end
      if (i == 4) o_v4 = period_vld;
    end
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    clear_fault = 1'b0;
  endtask

  // Five toggles of 10: first is discarded, lock on the fifth.
  task automatic lock_seq(input string tag);
    for (int k = 0; k < 5; k++) begin
      toggle_wait(10, v, v4, hp, lk, fl, fc);
      if (v !== (k != 0)) begin errors++; $display("FAIL %s_vld%0d: got %b want %b", tag, k, v, (k != 0)); end
      checks++;
      if (lk !== (k == 4)) begin errors++; $display("FAIL %s_lk%0d: got %b want %b", tag, k, lk, (k == 4)); end
      checks++;
      if (k != 0) begin
        if (hp !== 8'd10) begin errors++; $display("FAIL %s_hp%0d: got %0d want 10", tag, k, hp); end
        checks++;
      end
      if (k == 1) begin
        if (v4 !== 1'b0) begin errors++; $display("FAIL %s_vld_pulse: got %b want 0", tag, v4); end
        checks++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    if ({half_period, period_vld, locked, fault, fault_code} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {half_period, period_vld, locked, fault, fault_code});
    end
    checks++;
  endtask

  task automatic test_lock();
    lock_seq("lock");
  endtask

  task automatic test_period_fault();
    toggle_wait(13, v, v4, hp, lk, fl, fc);
    if (lk !== 1'b1) begin errors++; $display("FAIL pf_still_locked: got %b want 1", lk); end
    checks++;
    toggle_wait(10, v, v4, hp, lk, fl, fc);
    if (hp !== 8'd13 || v !== 1'b1) begin errors++; $display("FAIL pf_hp: got %0d/%b want 13/1", hp, v); end
    checks++;
    if (fl !== 1'b1 || fc !== 2'b01 || lk !== 1'b0) begin
      errors++; $display("FAIL pf_fault: got fl=%b fc=%b lk=%b want 1 01 0", fl, fc, lk);
    end
    checks++;
    pulse_clear();
    if (fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL pf_clear: got fl=%b fc=%b want 0 00", fault, fault_code);
    end
    checks++;
    lock_seq("relock");
  endtask

  task automatic test_stall();
    for (int j = 1; j <= 8; j++) begin
      @(posedge clkin);
      @(negedge clkin);
      if (j == 5) begin
        if (locked !== 1'b1 || fault !== 1'b0) begin
          errors++; $display("FAIL stall_early: got lk=%b fl=%b want 1 0", locked, fault);
        end
        checks++;
      end
      if (j == 6) begin
        if (fault !== 1'b1 || fault_code !== 2'b10 || locked !== 1'b0) begin
          errors++; $display("FAIL stall_fault: got fl=%b fc=%b lk=%b want 1 10 0", fault, fault_code, locked);
        end
        checks++;
      end
    end
    pulse_clear();
    toggle_wait(10, v, v4, hp, lk, fl, fc);
    toggle_wait(10, v, v4, hp, lk, fl, fc);
    if (v !== 1'b1 || hp !== 8'd10 || lk !== 1'b0) begin
      errors++; $display("FAIL acq_meas: got v=%b hp=%0d lk=%b want 1 10 0", v, hp, lk);
    end
    checks++;
    bad = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clkin);
      @(negedge clkin);
      if (fault || locked) bad = 1'b1;
    end
    if (bad !== 1'b0) begin errors++; $display("FAIL acq_stall_nofault: got %b want 0", bad); end
    checks++;
    // Back in IDLE, so this edge is discarded.
    toggle_wait(9, v, v4, hp, lk, fl, fc);
    if (v !== 1'b0) begin errors++; $display("FAIL acq_stall_idle: got vld=%b want 0", v); end
    checks++;
  endtask

  task automatic test_tolerance();
    int waits [4] = '{11, 9, 11, 10};
    int meas  [4] = '{9, 11, 9, 11};
    for (int k = 0; k < 4; k++) begin
      toggle_wait(waits[k], v, v4, hp, lk, fl, fc);
      if (hp !== 8'(meas[k]) || lk !== (k == 3)) begin
        errors++; $display("FAIL tol_%0d: got hp=%0d lk=%b want %0d %b", k, hp, lk, meas[k], (k == 3));
      end
      checks++;
    end
  endtask

  task automatic test_restart();
    int waits [8] = '{10, 10, 12, 10, 10, 10, 10, 10};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      toggle_wait(waits[k], v, v4, hp, lk, fl, fc);
      if (lk !== (k == 7) || fl !== 1'b0) begin
        errors++; $display("FAIL restart_%0d: got lk=%b fl=%b want %b 0", k, lk, fl, (k == 7));
      end
      checks++;
      if (k == 3) begin
        if (hp !== 8'd12 || v !== 1'b1) begin errors++; $display("FAIL restart_hp12: got %0d/%b want 12/1", hp, v); end
        checks++;
      end
    end
  endtask

  task automatic test_phase();
    // Single-cycle equality: mem follows clk one cycle late.
    clk_mon = ~clk_mon;
    @(posedge clkin);
    @(negedge clkin);
    mem_clk_mon = ~clk_mon;
    bad = 1'b0;
    for (int j = 0; j < 9; j++) begin
      @(posedge clkin);
      @(negedge clkin);
      if (fault) bad = 1'b1;
    end
    if (bad !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL phase_glitch: got fl=%b lk=%b want 0 1", bad, locked);
    end
    checks++;
    // Sustained equality.
    clk_mon = ~clk_mon;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clkin);
      @(negedge clkin);
      if (j == 4) begin
`ifdef CLK_MON_PHASE_CHK_EN
        if (fault !== 1'b1 || fault_code !== 2'b11) begin
          errors++; $display("FAIL phase_fault: got fl=%b fc=%b want 1 11", fault, fault_code);
        end
`else
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
          errors++; $display("FAIL phase_off: got fl=%b fc=%b want 0 00", fault, fault_code);
        end
`endif
        checks++;
      end
    end
  endtask

  task automatic test_reset_and_clear();
    logic [1:0] exp_fc;
`ifdef CLK_MON_PHASE_CHK_EN
    exp_fc = 2'b11;
`else
    exp_fc = 2'b01;
`endif
    track_mem = 1'b1;
    toggle_wait(13, v, v4, hp, lk, fl, fc);
    toggle_wait(5, v, v4, hp, lk, fl, fc);
    if (fl !== 1'b1 || fc !== exp_fc) begin
      errors++; $display("FAIL pre_reset_fault: got fl=%b fc=%b want 1 %b", fl, fc, exp_fc);
    end
    checks++;
    reset = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    if ({half_period, period_vld, locked, fault, fault_code} !== 13'd0) begin
      errors++;
      $display("FAIL midop_reset: got %h want 0", {half_period, period_vld, locked, fault, fault_code});
    end
    checks++;
    do_reset();
    lock_seq("lock6");
    for (int j = 1; j <= 5; j++) begin
      @(posedge clkin);
      @(negedge clkin);
    end
    // Stall is detected in this cycle; clear arrives with it.
    pulse_clear();
    if (fault !== 1'b0 || locked !== 1'b0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL clear_same_cycle: got fl=%b lk=%b fc=%b want 0 0 00", fault, locked, fault_code);
    end
    checks++;
    toggle_wait(10, v, v4, hp, lk, fl, fc);
    if (v !== 1'b0) begin errors++; $display("FAIL clear_idle: got vld=%b want 0", v); end
    checks++;
  endtask

  initial begin
    reset       = 1'b1;
    clk_mon     = 1'b0;
    mem_clk_mon = 1'b1;
    clear_fault = 1'b0;
    track_mem   = 1'b1;
    test_reset();
    test_lock();
    test_period_fault();
    test_stall();
    test_tolerance();
    test_restart();
    test_phase();
    test_reset_and_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
